run_ctrl: RTL and testbench
===========================

# run_ctrl

Run controller that sequences the single-cycle processor core through one program execution per request. It sits between the testbench/host `req`/`done` handshake and the core: it holds the core in reset while idle, releases it for a run, watches the program counter for the end-of-program address, and counts execution cycles. An optional watchdog aborts runaway programs.

## Interface

Parameters:
- `D`, 12, program counter width (matches core PC).
- `DONE_PC`, 128, PC value that marks program completion.
- `CW`, 16, cycle-counter width.
- `WDOG_LIMIT`, 16'hFFFF, RUN-cycle count at which the watchdog fires (used only with `RUN_CTRL_WDOG_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 1: run request, level-sensitive, sampled on `clk`.
- `prog_ctr` in D: current core PC.
- `core_reset` out 1: synchronous reset to the core (PC, flags), active-high.
- `core_run` out 1: core clock enable; the core advances only when 1.
- `busy` out 1: high in CLEAR and RUN.
- `done` out 1: run finished, held until `req` drops.
- `timeout` out 1: last run ended by watchdog.
- `cycles` out CW: RUN cycles of the current/last run.

## Operation

- States: IDLE, CLEAR, RUN, DONE. Moore outputs decoded from the state register.
- IDLE: `core_reset`=1, `core_run`=0. `req`=1 -> CLEAR.
- CLEAR (exactly one cycle): `core_reset`=1, `core_run`=0, `busy`=1. `cycles` and `timeout` are cleared to 0. -> RUN. If `req`=0 -> IDLE.
- RUN: `core_reset`=0, `core_run`=1, `busy`=1. `cycles` increments by 1 every RUN cycle and saturates at all-ones (no wrap).
  - `prog_ctr`==`DONE_PC` -> DONE.
  - `req`=0 (abort) -> IDLE. `done` is never asserted; `cycles` holds its value.
  - If `prog_ctr` match and `req`=0 occur in the same cycle, the abort wins -> IDLE.
- DONE: `done`=1, `core_run`=0, `core_reset`=0 (core state is preserved for inspection). Stays in DONE while `req`=1. `req`=0 -> IDLE.
- `cycles` and `timeout` hold their values through DONE and IDLE until the next CLEAR.
- Width rule: the PC compare is an equality test over the full `D` bits. `DONE_PC` must be less than 2^D.

## Timing

- Reset values (async assertion): state IDLE, `core_reset`=1, `core_run`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0.
- `req` high sampled at edge N: CLEAR during cycle N+1, RUN from N+2.
- The `prog_ctr` match is sampled at the end of a RUN cycle. `done` rises the following cycle.
- `done` lasts at least 1 cycle. `req` low sampled in DONE -> IDLE on the next cycle.
- The minimum gap between runs is one IDLE cycle.
- Reset asserted mid-run: immediate return to IDLE with reset values. The core is held in reset via `core_reset`=1.

## Configuration

- `RUN_CTRL_WDOG_EN` defined:
  - In RUN, when `cycles`==`WDOG_LIMIT` (after the increment), the next state is DONE with `timeout`=1.
  - If the PC match coincides with the watchdog, the PC match wins and `timeout` stays 0.
- Not defined: no watchdog logic, `timeout` is tied to 0, and `WDOG_LIMIT` is ignored. A program that never reaches `DONE_PC` runs until `req` drops.

## Structure

- Package `run_ctrl_pkg`:
  - `run_state_t` enum (IDLE, CLEAR, RUN, DONE).
  - Default `DONE_PC` and `CW` constants shared with `top_level`.
- Sub-module `sat_counter`: parameterised width, synchronous clear, enable, saturating increment. Instantiated for `cycles`.

## Test plan

- Reset then `req`=1 with `prog_ctr` reaching 128 on the 5th RUN cycle: `core_reset` high 1 cycle, `core_run` high 5 cycles, `done`=1 with `cycles`=5; drop `req`, IDLE next cycle.
- `req` dropped on the 3rd RUN cycle: IDLE, `done` never high, `cycles`=3 held.
- Same-cycle `prog_ctr`=128 and `req`=0: IDLE, `done`=0.
- `RUN_CTRL_WDOG_EN` with `WDOG_LIMIT`=10 and PC never matching: DONE after 10 RUN cycles, `timeout`=1, `cycles`=10. Next run clears `timeout` in CLEAR.
- CW=4 with no watchdog and 20 RUN cycles: `cycles` saturates at 15.
- Async `reset` low mid-RUN, between clock edges: outputs return to reset values immediately.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// run_ctrl_pkg
// Shared types and default constants for the run controller.
//   run_state_t     : controller state encoding (IDLE, CLEAR, RUN, DONE)
//   RC_D_DEF        : default program-counter width
//   RC_DONE_PC_DEF  : default end-of-program PC value
//   RC_CW_DEF       : default cycle-counter width
// These defaults are shared with top_level so both agree on the PC width
// and the completion address.
// ----------------------------------------------------------------------------
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

    localparam int unsigned RC_D_DEF       = 12;
    localparam int unsigned RC_DONE_PC_DEF = 128;
    localparam int unsigned RC_CW_DEF      = 16;

endpackage : run_ctrl_pkg

// File: rtl/run_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk     in  1 : clock, rising edge
//   rst_n   in  1 : asynchronous active-low reset, count -> 0
//   i_clr   in  1 : synchronous clear (takes priority over i_en)
//   i_en    in  1 : increment enable
//   o_count out W : current count; sticks at all-ones instead of wrapping
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         w_full;

    assign w_full = &r_count;

    always_comb begin
        w_count_next = r_count;
        if (i_clr) begin
            w_count_next = '0;
        end else if (i_en && !w_full) begin
            w_count_next = r_count + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count = r_count;

endmodule : sat_counter

// File: rtl/run_ctrl.sv
// ----------------------------------------------------------------------------
// run_ctrl
// Sequences the single-cycle core through one program execution per request.
// Holds the core in reset while idle, releases it for a run, stops when the
// PC reaches DONE_PC and counts the RUN cycles of each run.
//
// Optional feature macro: RUN_CTRL_WDOG_EN
//   When defined, a watchdog ends a run in DONE with timeout=1 once the
//   RUN-cycle count reaches WDOG_LIMIT. When undefined, timeout is tied to 0.
//
// Ports:
//   clk        in  1  : clock, rising edge
//   reset      in  1  : asynchronous active-low reset
//   req        in  1  : run request (level)
//   prog_ctr   in  D  : current core PC
//   core_reset out 1  : synchronous reset to the core, active-high
//   core_run   out 1  : core clock enable
//   busy       out 1  : high in CLEAR and RUN
//   done       out 1  : run finished, held until req drops
//   timeout    out 1  : last run ended by the watchdog
//   cycles     out CW : RUN cycles of the current/last run (saturating)
// ----------------------------------------------------------------------------
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned D          = RC_D_DEF,
    parameter int unsigned DONE_PC    = RC_DONE_PC_DEF,
    parameter int unsigned CW         = RC_CW_DEF,
    parameter int unsigned WDOG_LIMIT = 16'hFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_reset,
    output logic          core_run,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    run_state_t    r_state;
    run_state_t    w_next_state;
    logic          w_pc_hit;
    logic          w_wdog_hit;
    logic          w_cnt_clr;
    logic          w_cnt_en;
    logic [CW-1:0] w_cycles;

    // Full-width equality; DONE_PC is required to fit in D bits.
    assign w_pc_hit = (prog_ctr == D'(DONE_PC));

    assign w_cnt_clr = (r_state == CLEAR);
    assign w_cnt_en  = (r_state == RUN);

    sat_counter #(
        .W (CW)
    ) u_cycles (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cycles)
    );

    assign cycles = w_cycles;

`ifdef RUN_CTRL_WDOG_EN
    logic [CW-1:0] w_cycles_inc;
    logic          r_timeout;

    // The watchdog compares against the count this RUN cycle is about to
    // write, so a limit of N ends the run after exactly N RUN cycles.
    assign w_cycles_inc = (&w_cycles) ? w_cycles : (w_cycles + CW'(1));
    assign w_wdog_hit   = (w_cycles_inc == CW'(WDOG_LIMIT));

    // Set only when the watchdog actually causes RUN -> DONE: an abort or
    // a coincident PC match both take precedence and leave timeout at 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timeout <= 1'b0;
        end else if (r_state == CLEAR) begin
            r_timeout <= 1'b0;
        end else if ((r_state == RUN) && req && !w_pc_hit && w_wdog_hit) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdog_hit = 1'b0;
    assign timeout    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; in RUN an abort outranks every completion source.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_next_state = CLEAR;
                end
            end
            CLEAR: begin
                w_next_state = req ? RUN : IDLE;
            end
            RUN: begin
                if (!req) begin
                    w_next_state = IDLE;
                end else if (w_pc_hit || w_wdog_hit) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                if (!req) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Moore outputs. In DONE the core is neither reset nor clocked so its
    // final state stays visible for inspection.
    always_comb begin
        core_reset = 1'b0;
        core_run   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            IDLE: begin
                core_reset = 1'b1;
            end
            CLEAR: begin
                core_reset = 1'b1;
                busy       = 1'b1;
            end
            RUN: begin
                core_run = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                core_reset = 1'b1;
            end
        endcase
    end

endmodule : run_ctrl

// File: tb/tb_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_run_ctrl
// Directed bench for run_ctrl. A main instance (CW=16, WDOG_LIMIT=10) covers
// reset, normal completion, abort, same-cycle abort/match, watchdog (when
// RUN_CTRL_WDOG_EN is defined) and asynchronous reset; a second instance
// with CW=4 covers counter saturation.
// ----------------------------------------------------------------------------
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_s;
    logic [11:0] prog_ctr;
    logic [11:0] prog_ctr_s;

    logic        core_reset, core_run, busy, done, timeout;
    logic [15:0] cycles;
    logic        core_reset_s, core_run_s, busy_s, done_s, timeout_s;
    logic [3:0]  cycles_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    run_ctrl #(
        .D          (12),
        .DONE_PC    (128),
        .CW         (16),
        .WDOG_LIMIT (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .prog_ctr   (prog_ctr),
        .core_reset (core_reset),
        .core_run   (core_run),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycles     (cycles)
    );

    run_ctrl #(
        .D          (12),
        .DONE_PC    (128),
        .CW         (4),
        .WDOG_LIMIT (15)
    ) dut_s (
        .clk        (clk),
        .reset      (reset),
        .req        (req_s),
        .prog_ctr   (prog_ctr_s),
        .core_reset (core_reset_s),
        .core_run   (core_run_s),
        .busy       (busy_s),
        .done       (done_s),
        .timeout    (timeout_s),
        .cycles     (cycles_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b0;
        req        = 1'b0;
        req_s      = 1'b0;
        prog_ctr   = '0;
        prog_ctr_s = '0;
        tick();
        tick();

        // Reset values
        check("rst_core_reset", 32'(core_reset), 1);
        check("rst_core_run",   32'(core_run),   0);
        check("rst_busy",       32'(busy),       0);
        check("rst_done",       32'(done),       0);
        check("rst_timeout",    32'(timeout),    0);
        check("rst_cycles",     32'(cycles),     0);

        reset = 1'b1;
        tick();
        check("idle_core_reset", 32'(core_reset), 1);
        check("idle_busy",       32'(busy),       0);

        // Normal run: PC hits 128 on the 5th RUN cycle
        req = 1'b1;
        tick();
        check("clr_core_reset", 32'(core_reset), 1);
        check("clr_busy",       32'(busy),       1);
        check("clr_core_run",   32'(core_run),   0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("run%0d_core_run", i),   32'(core_run),   1);
            check($sformatf("run%0d_core_reset", i), 32'(core_reset), 0);
            prog_ctr = (i == 5) ? 12'd128 : 12'(i);
        end
        tick();
        check("done_done",       32'(done),       1);
        check("done_cycles",     32'(cycles),     5);
        check("done_core_run",   32'(core_run),   0);
        check("done_core_reset", 32'(core_reset), 0);
        check("done_busy",       32'(busy),       0);
        check("done_timeout",    32'(timeout),    0);
        prog_ctr = '0;
        tick();
        check("done_hold", 32'(done), 1);
        req = 1'b0;
        tick();
        check("done_exit_done",       32'(done),       0);
        check("done_exit_core_reset", 32'(core_reset), 1);
        check("done_exit_cycles",     32'(cycles),     5);

        // Abort on the 3rd RUN cycle
        req = 1'b1;
        tick();
        tick();
        check("abort_run1_cycles", 32'(cycles), 0);
        tick();
        tick();
        check("abort_run3_core_run", 32'(core_run), 1);
        req = 1'b0;
        tick();
        check("abort_done",       32'(done),       0);
        check("abort_core_reset", 32'(core_reset), 1);
        check("abort_cycles",     32'(cycles),     3);
        tick();
        check("abort_hold_done",   32'(done),   0);
        check("abort_hold_cycles", 32'(cycles), 3);

        // PC match and req drop in the same cycle: abort wins
        req = 1'b1;
        tick();
        tick();
        check("same_run1_cycles", 32'(cycles), 0);
        prog_ctr = 12'd128;
        req      = 1'b0;
        tick();
        check("same_done",       32'(done),       0);
        check("same_busy",       32'(busy),       0);
        check("same_core_reset", 32'(core_reset), 1);
        check("same_cycles",     32'(cycles),     1);
        prog_ctr = '0;
        tick();
        check("same_hold_done", 32'(done), 0);

`ifdef RUN_CTRL_WDOG_EN
        // Watchdog at 10 RUN cycles, PC never matching
        req = 1'b1;
        tick();
        repeat (10) tick();
        check("wdog_run10_core_run", 32'(core_run), 1);
        check("wdog_run10_done",     32'(done),     0);
        tick();
        check("wdog_done",     32'(done),     1);
        check("wdog_timeout",  32'(timeout),  1);
        check("wdog_cycles",   32'(cycles),   10);
        check("wdog_core_run", 32'(core_run), 0);
        req = 1'b0;
        tick();
        check("wdog_idle_timeout", 32'(timeout), 1);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        check("wdog_clr_timeout", 32'(timeout), 0);
        check("wdog_clr_cycles",  32'(cycles),  0);
        check("wdog_clr_busy",    32'(busy),    0);
`endif

        // Saturation with CW=4
        req_s = 1'b1;
        tick();
        tick();
        repeat (15) tick();
        check("sat_15_cycles", 32'(cycles_s), 15);
        repeat (5) tick();
        check("sat_20_cycles", 32'(cycles_s), 15);
`ifndef RUN_CTRL_WDOG_EN
        check("sat_20_core_run", 32'(core_run_s), 1);
`endif
        req_s = 1'b0;
        tick();

        // Asynchronous reset between clock edges mid-RUN
        req = 1'b1;
        tick();
        tick();
        tick();
        check("arst_pre_cycles",   32'(cycles),   1);
        check("arst_pre_core_run", 32'(core_run), 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_core_reset", 32'(core_reset), 1);
        check("arst_core_run",   32'(core_run),   0);
        check("arst_busy",       32'(busy),       0);
        check("arst_done",       32'(done),       0);
        check("arst_timeout",    32'(timeout),    0);
        check("arst_cycles",     32'(cycles),     0);
        req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("arst_after_core_reset", 32'(core_reset), 1);
        check("arst_after_busy",       32'(busy),       0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_run_ctrl
